// File: rtl/cnn_line_buffer_ring_if.sv
// Write/read/release bundle between the pixel producer, the ring line buffer and the MAC array.
interface cnn_line_buffer_ring_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMAGE_WIDTH     = 32,
   parameter int KERNEL_ROW_SIZE = 3,
   parameter int SPARE_ROWS      = 1
);
   localparam int NUM_ROWS       = KERNEL_ROW_SIZE + SPARE_ROWS;
   localparam int COL_ADDR_WIDTH = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int COUNT_WIDTH    = $clog2(NUM_ROWS + 1);

   logic                                         frame_start;
   logic                                         wvalid;
   logic                                         wready;
   logic [DATA_WIDTH-1:0]                        wdata;
   logic                                         renable;
   logic [COL_ADDR_WIDTH-1:0]                    raddress;
   logic [0:KERNEL_ROW_SIZE-1][DATA_WIDTH-1:0]   rdata;
   logic                                         rvalid;
   logic                                         row_release;
   logic                                         window_ready;
   logic [COUNT_WIDTH-1:0]                       row_count;
   logic                                         err_sticky;

   modport master (
      output frame_start, wvalid, wdata, renable, raddress, row_release,
      input  wready, rdata, rvalid, window_ready, row_count, err_sticky
   );

   modport slave (
      input  frame_start, wvalid, wdata, renable, raddress, row_release,
      output wready, rdata, rvalid, window_ready, row_count, err_sticky
   );
endinterface

// File: rtl/cnn_line_buffer_ring.sv
// K-row line buffer built as a ring of row RAMs: each pixel is written once, the window
// is the K oldest complete rows, and spare rows let the writer run ahead of the consumer.
module cnn_line_buffer_ring #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMAGE_WIDTH     = 32,
   parameter int KERNEL_ROW_SIZE = 3,
   parameter int SPARE_ROWS      = 1
) (
   input logic                   i_clock,
   input logic                   i_reset,
   cnn_line_buffer_ring_if.slave bus
);
   localparam int NUM_ROWS       = KERNEL_ROW_SIZE + SPARE_ROWS;
   localparam int COL_ADDR_WIDTH = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ROW_PTR_WIDTH  = $clog2(NUM_ROWS);
   localparam int COUNT_WIDTH    = $clog2(NUM_ROWS + 1);

   localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL     = COL_ADDR_WIDTH'(IMAGE_WIDTH - 1);
   localparam logic [ROW_PTR_WIDTH-1:0]  LAST_ROW     = ROW_PTR_WIDTH'(NUM_ROWS - 1);
   localparam logic [COUNT_WIDTH-1:0]    FULL_COUNT   = COUNT_WIDTH'(NUM_ROWS);
   localparam logic [COUNT_WIDTH-1:0]    WINDOW_COUNT = COUNT_WIDTH'(KERNEL_ROW_SIZE);
   localparam logic [ROW_PTR_WIDTH:0]    RING_SIZE    = (ROW_PTR_WIDTH + 1)'(NUM_ROWS);

   logic [COL_ADDR_WIDTH-1:0]              wr_col;
   logic [ROW_PTR_WIDTH-1:0]               wr_row;
   logic [ROW_PTR_WIDTH-1:0]               old_row;
   logic [ROW_PTR_WIDTH-1:0]               map_row_p1;
   logic [COUNT_WIDTH-1:0]                 row_count;
   logic [COUNT_WIDTH-1:0]                 row_count_next;
   logic                                   window_ready;
   logic                                   err_sticky;
   logic                                   vld_p1;
   logic                                   has_data_p1;
   logic                                   wr_fire;
   logic                                   row_done;
   logic                                   rel_fire;
   logic                                   rd_fire;
   logic                                   bad_access;
   logic [ROW_PTR_WIDTH:0]                 sel;
   logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]    ram_q_p1;

   // frame_start outranks every other request in its cycle
   assign bus.wready = (row_count < FULL_COUNT) && !bus.frame_start;
   assign wr_fire    = bus.wvalid && bus.wready;
   assign row_done   = wr_fire && (wr_col == LAST_COL);
   assign rel_fire   = bus.row_release && window_ready && !bus.frame_start;
   assign rd_fire    = bus.renable && window_ready && !bus.frame_start;
   assign bad_access = (bus.row_release || bus.renable) && !window_ready && !bus.frame_start;

   always_comb begin
      row_count_next = row_count;
      if (row_done && !rel_fire)
         row_count_next = row_count + 1'b1;
      else if (!row_done && rel_fire)
         row_count_next = row_count - 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || bus.frame_start) begin
         wr_col       <= '0;
         wr_row       <= '0;
         old_row      <= '0;
         row_count    <= '0;
         window_ready <= 1'b0;
         err_sticky   <= 1'b0;
         vld_p1       <= 1'b0;
      end else begin
         if (wr_fire)
            wr_col <= row_done ? '0 : wr_col + 1'b1;
         if (row_done)
            wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
         if (rel_fire)
            old_row <= (old_row == LAST_ROW) ? '0 : old_row + 1'b1;
         row_count    <= row_count_next;
         window_ready <= (row_count_next >= WINDOW_COUNT);
         if (bad_access)
            err_sticky <= 1'b1;
         vld_p1 <= rd_fire;
      end
   end

   // ---- stage p1: read data and the row mapping captured in the request cycle ----
   always_ff @(posedge i_clock) begin
      if (i_reset)
         has_data_p1 <= 1'b0;
      else if (rd_fire)
         has_data_p1 <= 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (rd_fire)
         map_row_p1 <= old_row;
   end

   // One simple dual-port RAM per ring slot; read and write share a block so reads see old data.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] ram [IMAGE_WIDTH];
      logic [DATA_WIDTH-1:0] q_p1;

      always_ff @(posedge i_clock) begin
         if (wr_fire && (wr_row == ROW_PTR_WIDTH'(r)))
            ram[wr_col] <= bus.wdata;
         if (rd_fire)
            q_p1 <= ram[bus.raddress];
      end

      assign ram_q_p1[r] = q_p1;
   end

   always_comb begin
      bus.rdata = '0;
      sel       = '0;
      for (int k = 0; k < KERNEL_ROW_SIZE; k++) begin
         sel = {1'b0, map_row_p1} + (ROW_PTR_WIDTH + 1)'(k);
         if (sel >= RING_SIZE)
            sel = sel - RING_SIZE;
         if (has_data_p1)
            bus.rdata[k] = ram_q_p1[sel[ROW_PTR_WIDTH-1:0]];
      end
   end

   assign bus.rvalid       = vld_p1;
   assign bus.window_ready = window_ready;
   assign bus.row_count    = row_count;
   assign bus.err_sticky   = err_sticky;
endmodule

// File: tb/tb_cnn_line_buffer_ring.sv
// Directed bench for cnn_line_buffer_ring (K=3, SPARE=1, IMAGE_WIDTH=4): reads are scored
// against a queue of hand-computed column vectors, control outputs are checked inline.
module tb_cnn_line_buffer_ring;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int K  = 3;
   localparam int SP = 1;

   typedef struct {
      string            name;
      logic [K*DW-1:0]  data;
      int               due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;
   int   cyc    = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t push_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cnn_line_buffer_ring_if #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .KERNEL_ROW_SIZE(K), .SPARE_ROWS(SP)) bus ();

   cnn_line_buffer_ring #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .KERNEL_ROW_SIZE(K), .SPARE_ROWS(SP)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   function automatic logic [K*DW-1:0] pk(input int a, input int b, input int c);
      return {a, b, c};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input int v);
      bus.wvalid = 1'b1;
      bus.wdata  = v;
      tick();
      bus.wvalid = 1'b0;
   endtask

   task automatic expect_read(input string name, input logic [K*DW-1:0] d);
      push_e.name = name;
      push_e.data = d;
      push_e.due  = cyc + 1;
      sb.push_back(push_e);
   endtask

   task automatic rd(input string name, input int col, input logic [K*DW-1:0] d);
      bus.renable  = 1'b1;
      bus.raddress = 2'(col);
      expect_read(name, d);
      tick();
      bus.renable = 1'b0;
      tick();
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic release_row();
      bus.row_release = 1'b1;
      tick();
      bus.row_release = 1'b0;
   endtask

   // Monitor: every rvalid must match the oldest pending expectation, exactly one cycle late.
   always @(negedge clk) begin
      if (bus.rvalid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rvalid: got rvalid=1, expected no read pending");
         end else begin
            mon_e = sb.pop_front();
            check(mon_e.name, bus.rdata, mon_e.data);
            check({mon_e.name, "_latency"}, cyc, mon_e.due);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst             = 1'b1;
      bus.frame_start = 1'b0;
      bus.wvalid      = 1'b0;
      bus.wdata       = '0;
      bus.renable     = 1'b0;
      bus.raddress    = '0;
      bus.row_release = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_row_count", bus.row_count, 0);
      check("reset_window_ready", bus.window_ready, 0);
      check("reset_rvalid", bus.rvalid, 0);
      check("reset_err", bus.err_sticky, 0);
      check("reset_rdata", bus.rdata, 0);
      check("reset_wready", bus.wready, 1);

      // Fill
      for (int v = 0; v < 11; v++) wr(v);
      check("fill_count_11", bus.row_count, 2);
      check("fill_window_11", bus.window_ready, 0);
      wr(11);
      check("fill_count_12", bus.row_count, 3);
      check("fill_window_12", bus.window_ready, 1);
      rd("fill_rd_col2", 2, pk(2, 6, 10));

      // Backpressure
      frame();
      check("bp_frame_count", bus.row_count, 0);
      for (int v = 0; v < 16; v++) wr(v);
      check("bp_wready_full", bus.wready, 0);
      check("bp_count_full", bus.row_count, 4);
      bus.wvalid = 1'b1;
      bus.wdata  = 99;
      tick();
      check("bp_held_wready", bus.wready, 0);
      check("bp_held_count", bus.row_count, 4);
      release_row();
      check("bp_release_count", bus.row_count, 3);
      check("bp_wready_after_release", bus.wready, 1);
      tick();
      bus.wvalid = 1'b0;
      rd("bp_rd_col0", 0, pk(4, 8, 12));
      wr(100);
      wr(101);
      wr(102);
      check("bp_count_refill", bus.row_count, 4);
      release_row();
      rd("bp_rd_held_word", 0, pk(8, 12, 99));

      // Wrap: each new row completes in the same cycle as the oldest row is released
      frame();
      for (int v = 0; v < 12; v++) wr(v);
      for (int r = 3; r < 8; r++) begin
         for (int c = 0; c < 4; c++) begin
            check("wrap_wready", bus.wready, 1);
            if (c == 3) bus.row_release = 1'b1;
            wr(4 * r + c);
            bus.row_release = 1'b0;
         end
      end
      check("wrap_count", bus.row_count, 3);
      rd("wrap_rd_col3", 3, pk(23, 27, 31));

      // Simultaneous row completion, release and read
      frame();
      for (int v = 0; v < 15; v++) wr(v);
      bus.wvalid      = 1'b1;
      bus.wdata       = 15;
      bus.row_release = 1'b1;
      bus.renable     = 1'b1;
      bus.raddress    = 2'd1;
      expect_read("simul_rd_pre", pk(1, 5, 9));
      tick();
      bus.wvalid      = 1'b0;
      bus.row_release = 1'b0;
      bus.renable     = 1'b0;
      check("simul_count", bus.row_count, 3);
      check("simul_window", bus.window_ready, 1);
      tick();
      rd("simul_rd_post", 1, pk(5, 9, 13));

      // Errors
      frame();
      for (int v = 0; v < 8; v++) wr(v);
      check("err_pre_window", bus.window_ready, 0);
      release_row();
      check("err_release_count", bus.row_count, 2);
      check("err_release_sticky", bus.err_sticky, 1);
      frame();
      check("err_frame_clear", bus.err_sticky, 0);
      check("err_frame_count", bus.row_count, 0);
      for (int v = 0; v < 8; v++) wr(v);
      bus.renable  = 1'b1;
      bus.raddress = 2'd0;
      tick();
      bus.renable = 1'b0;
      check("err_read_sticky", bus.err_sticky, 1);
      check("err_read_rvalid", bus.rvalid, 0);
      check("err_rdata_hold", bus.rdata, pk(5, 9, 13));
      tick();

      // frame_start priority over write, release and read
      bus.frame_start = 1'b1;
      bus.wvalid      = 1'b1;
      bus.wdata       = 77;
      bus.renable     = 1'b1;
      bus.row_release = 1'b1;
      #1;
      check("fs_wready", bus.wready, 0);
      tick();
      bus.frame_start = 1'b0;
      bus.wvalid      = 1'b0;
      bus.renable     = 1'b0;
      bus.row_release = 1'b0;
      check("fs_count", bus.row_count, 0);
      check("fs_err", bus.err_sticky, 0);
      check("fs_rvalid", bus.rvalid, 0);
      for (int v = 0; v < 12; v++) wr(v);
      rd("fs_rd_col0", 0, pk(0, 4, 8));

      // Reset mid-row
      frame();
      for (int v = 0; v < 6; v++) wr(200 + v);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_count", bus.row_count, 0);
      check("rst_mid_window", bus.window_ready, 0);
      check("rst_mid_rdata", bus.rdata, 0);
      for (int v = 0; v < 12; v++) wr(v);
      check("rst_fill_count", bus.row_count, 3);
      check("rst_fill_window", bus.window_ready, 1);
      rd("rst_rd_col2", 2, pk(2, 6, 10));
      rd("rst_rd_col1", 1, pk(1, 5, 9));

      tick();
      tick();
      check("pending_reads", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
